// File: rtl/parking_gate_controller.sv
// Parking gate controller: arbitrates entry/exit requests, drives two gates
// and tracks occupancy of an 8-slot lot.
// Optional feature: define PARKING_GATE_TIMEOUT_EN to close a gate that has
// stayed open for GATE_TIMEOUT cycles without car_passed.
module parking_gate_controller #(
  parameter int unsigned GATE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [2:0] exit_slot,
  input  logic       car_passed,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       entry_reject,
  output logic       exit_err,
  output logic       gate_in_open,
  output logic       gate_out_open,
  output logic [2:0] assigned_slot,
  output logic [7:0] occupancy,
  output logic [3:0] parked,
  output logic [3:0] empty,
  output logic       timeout
);

  localparam int unsigned SLOTS   = 8;
  localparam int unsigned SLOT_W  = 3;
  localparam int unsigned COUNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    EXIT  = 2'd2
  } state_t;

  state_t              state;
  logic                exit_priority;
  logic [SLOT_W-1:0]   exit_slot_q;
  logic [SLOTS-1:0]    occ_next;
  logic [SLOT_W-1:0]   free_slot;
  logic                lot_full;
  logic                entry_ok;
  logic                exit_ok;
  logic                grant_entry;
  logic                grant_exit;

`ifdef PARKING_GATE_TIMEOUT_EN
  localparam int unsigned TIMER_W = 8;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_TIMEOUT - 1);
  logic [TIMER_W-1:0]  timer;
  logic                timer_expired;
`endif

  // Lowest-index free slot in the occupancy map.
  function automatic logic [SLOT_W-1:0] lowest_free(input logic [SLOTS-1:0] occ);
    lowest_free = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!occ[i]) lowest_free = SLOT_W'(i);
    end
  endfunction

  // Number of occupied slots.
  function automatic logic [COUNT_W-1:0] count_ones(input logic [SLOTS-1:0] v);
    count_ones = '0;
    for (int i = 0; i < SLOTS; i++) begin
      count_ones = count_ones + COUNT_W'(v[i]);
    end
  endfunction

  // Request eligibility and tie-break between simultaneous eligible requests.
  always_comb begin
    free_slot   = lowest_free(occupancy);
    lot_full    = &occupancy;
    entry_ok    = entry_req && !lot_full;
    exit_ok     = exit_req && occupancy[exit_slot];
    grant_entry = 1'b0;
    grant_exit  = 1'b0;
    if (state == IDLE) begin
      if (entry_ok && exit_ok) begin
        grant_exit  = exit_priority;
        grant_entry = !exit_priority;
      end else begin
        grant_entry = entry_ok;
        grant_exit  = exit_ok;
      end
    end
  end

`ifdef PARKING_GATE_TIMEOUT_EN
  // Gate has been open for the full allowance without a car passing.
  always_comb begin
    timer_expired = (state != IDLE) && !car_passed && (timer == TIMER_LAST);
  end
`endif

  // Occupancy after this cycle: only a completed passage changes it.
  always_comb begin
    occ_next = occupancy;
    if (car_passed) begin
      if (state == ENTRY) begin
        occ_next[assigned_slot] = 1'b1;
      end else if (state == EXIT) begin
        occ_next[exit_slot_q] = 1'b0;
      end
    end
  end

  // Occupancy map and derived counts, updated together.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
      parked    <= '0;
      empty     <= COUNT_W'(SLOTS);
    end else begin
      occupancy <= occ_next;
      parked    <= count_ones(occ_next);
      empty     <= COUNT_W'(SLOTS) - count_ones(occ_next);
    end
  end

`ifdef PARKING_GATE_TIMEOUT_EN
  // Open-gate cycle counter, restarted at every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (grant_entry || grant_exit) begin
      timer <= '0;
    end else if (state != IDLE && !car_passed && !timer_expired) begin
      timer <= timer + TIMER_W'(1);
    end
  end
`endif

  // Transaction FSM with registered gate drives and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      exit_priority <= 1'b1;
      exit_slot_q   <= '0;
      assigned_slot <= '0;
      gate_in_open  <= 1'b0;
      gate_out_open <= 1'b0;
      entry_ack     <= 1'b0;
      exit_ack      <= 1'b0;
      entry_reject  <= 1'b0;
      exit_err      <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      entry_ack    <= 1'b0;
      exit_ack     <= 1'b0;
      entry_reject <= 1'b0;
      exit_err     <= 1'b0;
      timeout      <= 1'b0;
      case (state)
        IDLE: begin
          // Refusals are reported even when the other side is granted.
          if (entry_req && lot_full) entry_reject <= 1'b1;
          if (exit_req && !occupancy[exit_slot]) exit_err <= 1'b1;
          if (grant_entry) begin
            state         <= ENTRY;
            entry_ack     <= 1'b1;
            gate_in_open  <= 1'b1;
            assigned_slot <= free_slot;
            exit_priority <= 1'b1;
          end else if (grant_exit) begin
            state         <= EXIT;
            exit_ack      <= 1'b1;
            gate_out_open <= 1'b1;
            exit_slot_q   <= exit_slot;
            exit_priority <= 1'b0;
          end
        end
        ENTRY: begin
          if (car_passed) begin
            state        <= IDLE;
            gate_in_open <= 1'b0;
          end
`ifdef PARKING_GATE_TIMEOUT_EN
          else if (timer_expired) begin
            state        <= IDLE;
            gate_in_open <= 1'b0;
            timeout      <= 1'b1;
          end
`endif
        end
        EXIT: begin
          if (car_passed) begin
            state         <= IDLE;
            gate_out_open <= 1'b0;
          end
`ifdef PARKING_GATE_TIMEOUT_EN
          else if (timer_expired) begin
            state         <= IDLE;
            gate_out_open <= 1'b0;
            timeout       <= 1'b1;
          end
`endif
        end
        default: begin
          state         <= IDLE;
          gate_in_open  <= 1'b0;
          gate_out_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed scoreboard bench for parking_gate_controller.
// Honours PARKING_GATE_TIMEOUT_EN to select the timeout or the hold-open check.
module tb_parking_gate_controller;

  localparam int unsigned GATE_TIMEOUT = 16;

  logic       clk;
  logic       rst;
  logic       entry_req;
  logic       exit_req;
  logic [2:0] exit_slot;
  logic       car_passed;
  logic       entry_ack;
  logic       exit_ack;
  logic       entry_reject;
  logic       exit_err;
  logic       gate_in_open;
  logic       gate_out_open;
  logic [2:0] assigned_slot;
  logic [7:0] occupancy;
  logic [3:0] parked;
  logic [3:0] empty;
  logic       timeout;

  typedef struct {
    string       tag;
    logic [25:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  parking_gate_controller #(.GATE_TIMEOUT(GATE_TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .entry_req    (entry_req),
    .exit_req     (exit_req),
    .exit_slot    (exit_slot),
    .car_passed   (car_passed),
    .entry_ack    (entry_ack),
    .exit_ack     (exit_ack),
    .entry_reject (entry_reject),
    .exit_err     (exit_err),
    .gate_in_open (gate_in_open),
    .gate_out_open(gate_out_open),
    .assigned_slot(assigned_slot),
    .occupancy    (occupancy),
    .parked       (parked),
    .empty        (empty),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector; parked/empty derived from the expected map.
  function automatic logic [25:0] ev(input bit ai, input bit ao, input bit rj,
                                     input bit er, input bit gi, input bit go,
                                     input bit to, input logic [2:0] sl,
                                     input logic [7:0] oc);
    logic [3:0] p;
    p  = 4'($countones(oc));
    ev = {ai, ao, rj, er, gi, go, to, sl, oc, p, 4'(8 - $countones(oc))};
  endfunction

  // Drive one cycle of stimulus, then check outputs just after the edge.
  task automatic step(input string tag, input bit r, input bit e, input bit x,
                      input logic [2:0] s, input bit cp, input logic [25:0] exp_v);
    exp_t got;
    logic [25:0] obs;
    rst        = r;
    entry_req  = e;
    exit_req   = x;
    exit_slot  = s;
    car_passed = cp;
    exp_q.push_back('{tag: tag, v: exp_v});
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    obs = {entry_ack, exit_ack, entry_reject, exit_err, gate_in_open, gate_out_open,
           timeout, assigned_slot, occupancy, parked, empty};
    n_cmp++;
    assert (obs === got.v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", got.tag, obs, got.v);
    end
  endtask

  initial begin
    logic [7:0] occ;
    rst        = 1'b1;
    entry_req  = 1'b0;
    exit_req   = 1'b0;
    exit_slot  = 3'd0;
    car_passed = 1'b0;
    @(posedge clk);
    #1;

    step("reset", 1, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,3'd0,8'h00));

    // Entry with three open cycles.
    step("e0_grant", 0, 1, 0, 0, 0, ev(1,0,0,0,1,0,0,3'd0,8'h00));
    step("e0_open1", 0, 0, 0, 0, 0, ev(0,0,0,0,1,0,0,3'd0,8'h00));
    step("e0_open2", 0, 0, 0, 0, 0, ev(0,0,0,0,1,0,0,3'd0,8'h00));
    step("e0_close", 0, 0, 0, 0, 1, ev(0,0,0,0,0,0,0,3'd0,8'h01));

    // Minimum transaction, then car_passed in IDLE is ignored.
    step("e1_grant", 0, 1, 0, 0, 0, ev(1,0,0,0,1,0,0,3'd1,8'h01));
    step("e1_close", 0, 0, 0, 0, 1, ev(0,0,0,0,0,0,0,3'd1,8'h03));
    step("idle_cp",  0, 0, 0, 0, 1, ev(0,0,0,0,0,0,0,3'd1,8'h03));
    step("e2_grant", 0, 1, 0, 0, 0, ev(1,0,0,0,1,0,0,3'd2,8'h03));
    step("e2_close", 0, 0, 0, 0, 1, ev(0,0,0,0,0,0,0,3'd2,8'h07));
    step("e3_grant", 0, 1, 0, 0, 0, ev(1,0,0,0,1,0,0,3'd3,8'h07));
    step("e3_close", 0, 0, 0, 0, 1, ev(0,0,0,0,0,0,0,3'd3,8'h0F));

    // Tie after an entry: exit wins; latched slot ignores later changes.
    step("tie1_grant", 0, 1, 1, 3'd2, 0, ev(0,1,0,0,0,1,0,3'd3,8'h0F));
    step("exit_hold",  0, 1, 0, 3'd5, 0, ev(0,0,0,0,0,1,0,3'd3,8'h0F));
    step("exit_close", 0, 1, 1, 3'd1, 1, ev(0,0,0,0,0,0,0,3'd3,8'h0B));
    // Tie after an exit: entry wins and takes the freed slot 2.
    step("tie2_grant", 0, 1, 1, 3'd1, 0, ev(1,0,0,0,1,0,0,3'd2,8'h0B));
    step("tie2_close", 0, 0, 1, 3'd1, 1, ev(0,0,0,0,0,0,0,3'd2,8'h0F));
    step("x1_grant",   0, 0, 1, 3'd1, 0, ev(0,1,0,0,0,1,0,3'd2,8'h0F));
    step("x1_close",   0, 0, 0, 3'd0, 1, ev(0,0,0,0,0,0,0,3'd2,8'h0D));

    // Exit of an empty slot, alone and together with an entry.
    step("xerr",       0, 0, 1, 3'd5, 0, ev(0,0,0,1,0,0,0,3'd2,8'h0D));
    step("xerr_pulse", 0, 0, 0, 3'd0, 0, ev(0,0,0,0,0,0,0,3'd2,8'h0D));
    step("xerr_entry", 0, 1, 1, 3'd1, 0, ev(1,0,0,1,1,0,0,3'd1,8'h0D));
    step("xerr_close", 0, 0, 0, 3'd0, 1, ev(0,0,0,0,0,0,0,3'd1,8'h0F));

    // Fill the lot.
    occ = 8'h0F;
    for (int i = 4; i < 8; i++) begin
      step("fill_grant", 0, 1, 0, 0, 0, ev(1,0,0,0,1,0,0,3'(i),occ));
      occ[i] = 1'b1;
      step("fill_close", 0, 0, 0, 0, 1, ev(0,0,0,0,0,0,0,3'(i),occ));
    end

    // Full lot: reject, and reject alongside a valid exit.
    step("reject",       0, 1, 0, 0, 0, ev(0,0,1,0,0,0,0,3'd7,8'hFF));
    step("reject_pulse", 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,3'd7,8'hFF));
    step("rej_exit",     0, 1, 1, 3'd6, 0, ev(0,1,1,0,0,1,0,3'd7,8'hFF));
    step("rej_exit_cls", 0, 0, 0, 3'd0, 1, ev(0,0,0,0,0,0,0,3'd7,8'hBF));

    // Entry without car_passed.
    step("hold_grant", 0, 1, 0, 0, 0, ev(1,0,0,0,1,0,0,3'd6,8'hBF));
`ifdef PARKING_GATE_TIMEOUT_EN
    for (int k = 1; k < GATE_TIMEOUT; k++) begin
      step("to_open", 0, 0, 0, 0, 0, ev(0,0,0,0,1,0,0,3'd6,8'hBF));
    end
    step("to_fire",  0, 0, 0, 0, 0, ev(0,0,0,0,0,0,1,3'd6,8'hBF));
    step("to_pulse", 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,3'd6,8'hBF));
    occ = 8'hBF;
`else
    for (int k = 0; k < GATE_TIMEOUT + 4; k++) begin
      step("hold_open", 0, 0, 0, 0, 0, ev(0,0,0,0,1,0,0,3'd6,8'hBF));
    end
    step("hold_close", 0, 0, 0, 0, 1, ev(0,0,0,0,0,0,0,3'd6,8'hFF));
    occ = 8'hFF;
`endif

    // Reset in the middle of an exit aborts it.
    step("rx_grant", 0, 0, 1, 3'd0, 0, ev(0,1,0,0,0,1,0,3'd6,occ));
    step("rx_hold",  0, 0, 0, 3'd0, 0, ev(0,0,0,0,0,1,0,3'd6,occ));
    step("rst_mid",  1, 0, 0, 3'd0, 1, ev(0,0,0,0,0,0,0,3'd0,8'h00));
    step("post_rst", 0, 0, 0, 3'd0, 0, ev(0,0,0,0,0,0,0,3'd0,8'h00));
    step("pr_grant", 0, 1, 0, 3'd0, 0, ev(1,0,0,0,1,0,0,3'd0,8'h00));
    step("rst_wins", 1, 1, 0, 3'd0, 1, ev(0,0,0,0,0,0,0,3'd0,8'h00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parking_gate_controller.md
PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 Parameter GATE_TIMEOUT, default 16: cycles a gate may stay open without car_passed (range 2..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 entry_req  input  1  level; car waiting at entry; held until entry_ack or entry_reject.
REQ-005 exit_req  input  1  level; car waiting at exit; held until exit_ack or exit_err.
REQ-006 exit_slot  input  3  slot index the exiting car vacates; valid while exit_req high.
REQ-007 car_passed  input  1  one-cycle pulse from gate sensor; car cleared the open gate.
REQ-008 entry_ack / exit_ack  output  1 each  one-cycle grant pulses.
REQ-009 entry_reject  output  1  one-cycle pulse; entry refused, lot full.
REQ-010 exit_err  output  1  one-cycle pulse; exit_slot not occupied.
REQ-011 gate_in_open / gate_out_open  output  1 each  gate drive levels; never both high.
REQ-012 assigned_slot  output  3  slot granted to current entering car; held through ENTRY.
REQ-013 occupancy  output  8  bit i = slot i occupied.
REQ-014 parked / empty  output  4 each  popcount of occupancy / 8 minus parked.
REQ-015 timeout  output  1  one-cycle pulse on gate timeout (see Configuration).

Function
REQ-016 FSM states IDLE, ENTRY, EXIT; all outputs registered.
REQ-017 IDLE: entry eligible = entry_req and parked<8; exit eligible = exit_req and occupancy[exit_slot]=1.
REQ-018 One eligible request in cycle N -> ack pulse and gate open at N+1; state ENTRY or EXIT.
REQ-019 Both eligible: alternate priority via last_grant flag; after reset exit wins first.
REQ-020 Entry grant: assigned_slot = lowest-index zero bit of occupancy.
REQ-021 entry_req with parked=8 in IDLE -> entry_reject at N+1, stay IDLE; exit still serviced that cycle if eligible.
REQ-022 exit_req with unoccupied exit_slot in IDLE -> exit_err at N+1, stay IDLE; entry still serviced if eligible.
REQ-023 ENTRY + car_passed -> next cycle: occupancy[assigned_slot] set, gate_in_open low, IDLE.
REQ-024 EXIT + car_passed -> next cycle: occupancy[latched exit_slot] cleared, gate_out_open low, IDLE.
REQ-025 exit_slot latched at grant; later changes ignored until IDLE.
REQ-026 car_passed in IDLE ignored; requests in ENTRY/EXIT wait, no pulses.
REQ-027 parked/empty update same cycle as occupancy; parked+empty=8 always.
REQ-028 Minimum transaction: grant, one open cycle, close; IDLE re-arbitrates immediately.

Reset
REQ-029 rst high at clock edge: state IDLE, occupancy 0, parked 0, empty 8, assigned_slot 0, gates closed, all pulses 0, timer 0, priority to exit.
REQ-030 Reset mid-ENTRY/EXIT aborts transaction, no occupancy update; rst has priority over all inputs.

Configuration
REQ-031 Macro PARKING_GATE_TIMEOUT_EN defined: timer counts open-gate cycles; no car_passed after GATE_TIMEOUT cycles -> gate closes, timeout pulses, occupancy unchanged, IDLE.
REQ-032 Macro undefined: no timer logic; gate stays open until car_passed; timeout tied 0.

Verification
REQ-033 After reset, entry_req=1, car_passed 3 cycles later -> entry_ack, assigned_slot=0, gate_in_open 3 cycles, occupancy=8'h01, parked=1, empty=7.
REQ-034 occupancy=8'h0B, entry_req+exit_req(slot 1) same cycle after reset -> exit first, occupancy=8'h09; then entry gets slot 1, occupancy=8'h0B.
REQ-035 occupancy=8'hFF, entry_req -> entry_reject one cycle, gates closed, parked=8, empty=0.
REQ-036 occupancy=8'h01, exit_req slot 5 -> exit_err one cycle, occupancy unchanged.
REQ-037 PARKING_GATE_TIMEOUT_EN defined, GATE_TIMEOUT=16, entry granted, no car_passed -> gate closes after 16 cycles, timeout pulse, occupancy unchanged.
REQ-038 rst asserted mid-EXIT from occupancy=8'h04 -> next cycle occupancy=0, gates closed, state IDLE.
